// File: rtl/sp_ram_pkg.sv
// rtl/sp_ram_pkg.sv - shared response type and constants for the single-port RAM initiator
package sp_ram_pkg;

    localparam int SP_RAM_RD_LATENCY = 1;
    localparam int SP_RAM_DATA_W     = 32;

    typedef struct packed {
        logic [SP_RAM_DATA_W-1:0] data;
        logic                     err;
        logic                     is_write;
    } sp_ram_resp_t;

endpackage

// File: rtl/sp_ram_resp_fifo.sv
// rtl/sp_ram_resp_fifo.sv - circular response FIFO, any depth >= 2, head reads as zero when empty
module sp_ram_resp_fifo
    import sp_ram_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = sp_ram_resp_t
) (
    input  logic clk,
    input  logic rstn,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    T               mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [CW-1:0]  count;

    // Pointers wrap explicitly so non-power-of-two depths behave.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/sp_ram_master.sv
// rtl/sp_ram_master.sv - req/gnt to single-port RAM initiator; SP_RAM_MASTER_OOR_ERR_EN enables out-of-range error responses
module sp_ram_master
    import sp_ram_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH = 32,
    parameter int RESP_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    input  logic [31:0]             addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic                    gnt_o,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    input  logic                    rready_i,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    if (RESP_DEPTH < 2 || RESP_DEPTH > 16 || SP_RAM_RD_LATENCY != 1) begin : g_bad_cfg
        $error("sp_ram_master: RESP_DEPTH must be 2..16 and RAM read latency 1");
    end

    logic [CNT_W-1:0] cnt;
    logic             grant;
    logic             pop;
    logic             oor;
    logic             inf_valid;
    logic             inf_write;
    logic             inf_err;
    sp_ram_resp_t     push_resp;
    sp_ram_resp_t     head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             unused_bits;

`ifdef SP_RAM_MASTER_OOR_ERR_EN
    assign oor = (addr_i >= 32'(RAM_SIZE));
`else
    assign oor = 1'b0;
`endif

    // cnt reserves a FIFO slot for every granted request, so pushes never overflow.
    assign grant = req_i && (cnt < CNT_W'(RESP_DEPTH));
    assign gnt_o = grant;

    // rstn_i gating keeps the RAM untouched while reset is held.
    assign ram_en_o    = grant && !oor && rstn_i;
    assign ram_we_o    = ram_en_o && we_i;
    assign ram_addr_o  = addr_i[ADDR_WIDTH-1:0];
    assign ram_wdata_o = wdata_i;
    assign ram_be_o    = be_i;

    assign pop      = rvalid_o && rready_i;
    assign rvalid_o = !fifo_empty;
    assign rdata_o  = DATA_WIDTH'(head.data);
    assign err_o    = head.err;

    assign unused_bits = ^{fifo_full, head.is_write, addr_i};

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt       <= '0;
            inf_valid <= 1'b0;
            inf_write <= 1'b0;
            inf_err   <= 1'b0;
        end else begin
            cnt       <= cnt + CNT_W'(grant) - CNT_W'(pop);
            inf_valid <= grant;
            if (grant) begin
                inf_write <= we_i;
                inf_err   <= oor;
            end
        end
    end

    always_comb begin
        push_resp          = '0;
        push_resp.is_write = inf_write;
        push_resp.err      = inf_err;
        if (!inf_write && !inf_err) begin
            push_resp.data = SP_RAM_DATA_W'(ram_rdata_i);
        end
    end

    sp_ram_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (sp_ram_resp_t)
    ) u_resp_fifo (
        .clk   (clk),
        .rstn  (rstn_i),
        .push  (inf_valid),
        .din   (push_resp),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_sp_ram_master.sv
// tb/tb_sp_ram_master.sv - randomized self-checking bench for sp_ram_master
module tb_sp_ram_master;

    localparam int RAM_SIZE = 32768;
    localparam int AW       = 15;
    localparam int DEPTH    = 4;
    localparam int WORDS    = RAM_SIZE / 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } rsp_t;

    logic          clk      = 1'b0;
    logic          rstn_i   = 1'b0;
    logic          req_i    = 1'b0;
    logic [31:0]   addr_i   = '0;
    logic          we_i     = 1'b0;
    logic [31:0]   wdata_i  = '0;
    logic [3:0]    be_i     = '0;
    logic          rready_i = 1'b0;
    logic          gnt_o;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic          ram_en_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_wdata_o;
    logic [3:0]    ram_be_o;
    logic [31:0]   ram_rdata_i;

    logic [31:0] ram_mem [0:WORDS-1] = '{default: '0};
    logic [31:0] ref_mem [0:WORDS-1] = '{default: '0};

    req_t req_q[$];
    rsp_t exp_q[$];
    rsp_t got_q[$];
    int   cyc      = 0;
    logic tick_gnt = 1'b0;
    logic tick_en  = 1'b0;
    int   n_tests  = 0;
    int   n_fail   = 0;

    logic        hold_pend = 1'b0;
    logic [31:0] h_addr, h_wdata;
    logic        h_we;
    logic [3:0]  h_be;

    sp_ram_master #(
        .RAM_SIZE   (RAM_SIZE),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (32),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rstn_i      (rstn_i),
        .req_i       (req_i),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .gnt_o       (gnt_o),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .rready_i    (rready_i),
        .ram_en_o    (ram_en_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_be_o    (ram_be_o),
        .ram_rdata_i (ram_rdata_i)
    );

    always #5 clk = ~clk;

    // RAM wrapper: one-cycle read latency, byte-enabled writes
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (ram_be_o[b]) ram_mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
            end else begin
                ram_rdata_i <= ram_mem[ram_addr_o[AW-1:2]];
            end
        end
    end

    // upstream rule: a pending request is held unchanged until granted
    always @(posedge clk) begin
        if (rstn_i && hold_pend &&
            !(req_i && addr_i == h_addr && we_i == h_we && wdata_i == h_wdata && be_i == h_be))
            $error("request changed before grant");
        hold_pend <= rstn_i && req_i && !gnt_o;
        h_addr    <= addr_i;
        h_we      <= we_i;
        h_wdata   <= wdata_i;
        h_be      <= be_i;
    end

    // one clock: sample at negedge, log grants into the model and pops into got_q
    task automatic tick();
        rsp_t e;
        @(negedge clk);
        cyc++;
        tick_gnt = req_i && gnt_o;
        tick_en  = ram_en_o;
        if (tick_gnt) begin
            int   w;
            logic oor;
            w   = int'(addr_i % 32'(RAM_SIZE)) / 4;
            oor = 1'b0;
`ifdef SP_RAM_MASTER_OOR_ERR_EN
            oor = (addr_i >= 32'(RAM_SIZE));
`endif
            e.cyc  = cyc;
            e.err  = oor;
            e.data = '0;
            if (!oor && we_i) begin
                for (int b = 0; b < 4; b++)
                    if (be_i[b]) ref_mem[w][8*b +: 8] = wdata_i[8*b +: 8];
            end else if (!oor) begin
                e.data = ref_mem[w];
            end
            exp_q.push_back(e);
        end
        if (rvalid_o && rready_i) begin
            e.data = rdata_o;
            e.err  = err_o;
            e.cyc  = cyc;
            got_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic rr);
        req_t r;
        if (req_q.size() > 0) begin
            r       = req_q[0];
            req_i   = 1'b1;
            addr_i  = r.addr;
            we_i    = r.we;
            wdata_i = r.wdata;
            be_i    = r.be;
        end else begin
            req_i = 1'b0;
        end
        rready_i = rr;
        tick();
        if (tick_gnt && req_q.size() > 0) begin
            r = req_q.pop_front();
            if (req_q.size() == 0) req_i = 1'b0;
        end
    endtask

    task automatic drain(input int budget, input bit rand_rdy, output bit ok);
        int n = 0;
        while ((req_q.size() > 0 || got_q.size() < exp_q.size()) && n < budget) begin
            step(rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        ok = (n < budget);
        repeat (3) step(1'b1);
    endtask

    function automatic void add(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] b);
        req_t r;
        r.addr  = a;
        r.we    = w;
        r.wdata = d;
        r.be    = b;
        req_q.push_back(r);
    endfunction

    function automatic void clear_logs();
        exp_q.delete();
        got_q.delete();
    endfunction

    task automatic test_reset();
        rstn_i   = 1'b0;
        req_i    = 1'b0;
        rready_i = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({gnt_o, rvalid_o, err_o, ram_en_o, ram_we_o} !== 5'b0 || rdata_o !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: gnt/rvalid/err/en/we=%b rdata=%h, required 00000 rdata=0",
                     {gnt_o, rvalid_o, err_o, ram_en_o, ram_we_o}, rdata_o);
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; be_i = 4'hF; wdata_i = 32'h5A5A5A5A;
        #1;
        n_tests++;
        if (gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_gnt_follows_req: gnt=%b, required 1", gnt_o);
        end
        n_tests++;
        if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_ram_access: en=%b we=%b, required 0 0", ram_en_o, ram_we_o);
        end
        req_i = 1'b0; we_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        tick();
        clear_logs();
    endtask

    task automatic test_write_read();
        bit ok;
        clear_logs();
        add(32'h10, 1'b1, 32'hDEADBEEF, 4'hF);
        add(32'h10, 1'b0, 32'h0, 4'h0);
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 2) begin
            n_fail++;
            $display("FAIL wr_count: got %0d responses, required 2", got_q.size());
        end
        n_tests++;
        if (got_q.size() < 2 || got_q[1].data !== 32'hDEADBEEF || got_q[1].err !== 1'b0 || got_q[0].data !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_data: write rsp %h, read rsp %h err %b, required 0 / deadbeef / 0",
                     got_q[0].data, got_q[1].data, got_q[1].err);
        end
        n_tests++;
        if (got_q.size() < 2 || got_q[1].cyc - exp_q[1].cyc != 2 || exp_q[1].cyc != exp_q[0].cyc + 1) begin
            n_fail++;
            $display("FAIL wr_latency: read grant cyc %0d rsp cyc %0d, required rsp = grant + 2",
                     exp_q[1].cyc, got_q[1].cyc);
        end
    endtask

    task automatic test_byte_write();
        bit ok;
        clear_logs();
        add(32'h20, 1'b1, 32'h11223344, 4'hF);
        add(32'h20, 1'b1, 32'h0000AB00, 4'b0010);
        add(32'h20, 1'b0, 32'h0, 4'h0);
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 3 || got_q[1].data !== 32'h0 || got_q[2].data !== 32'h1122AB44) begin
            n_fail++;
            $display("FAIL byte_write: %0d rsps, write rsp %h, read %h, required 3 / 0 / 1122ab44",
                     got_q.size(), got_q[1].data, got_q[2].data);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        for (int i = 0; i < 8; i++) add(32'h100 + 32'(4 * i), 1'b1, $urandom, 4'hF);
        drain(100, 1'b0, ok);
        clear_logs();
        for (int i = 0; i < 8; i++) add(32'h100 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != exp_q.size() || exp_q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_count: %0d rsps for %0d grants, required 8", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (i >= exp_q.size() || i >= got_q.size() || exp_q[i].cyc != exp_q[0].cyc + i ||
                got_q[i].cyc != exp_q[0].cyc + 2 + i || got_q[i].data !== exp_q[i].data) begin
                n_fail++;
                $display("FAIL b2b[%0d]: grant cyc %0d rsp cyc %0d data %h, required grant %0d rsp %0d data %h",
                         i, exp_q[i].cyc, got_q[i].cyc, got_q[i].data, exp_q[0].cyc + i,
                         exp_q[0].cyc + 2 + i, exp_q[i].data);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int grants = 0;
        clear_logs();
        for (int i = 0; i < 6; i++) add(32'h200 + 32'(4 * i), 1'b1, $urandom, 4'hF);
        drain(100, 1'b0, ok);
        clear_logs();
        for (int i = 0; i < 6; i++) add(32'h200 + 32'(4 * i), 1'b0, 32'h0, 4'h0);
        repeat (8) begin
            step(1'b0);
            if (tick_gnt) grants++;
        end
        n_tests++;
        if (grants != DEPTH || tick_gnt !== 1'b0 || exp_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL bp_stall: %0d grants, last gnt %b, outstanding %0d, required %0d / 0 / %0d",
                     grants, tick_gnt, exp_q.size(), DEPTH, DEPTH);
        end
        n_tests++;
        if (rvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_rvalid: rvalid=%b, required 1", rvalid_o);
        end
        step(1'b1);
        n_tests++;
        if (tick_gnt !== 1'b0 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL bp_pop: gnt=%b pops=%0d, required 0 / 1", tick_gnt, got_q.size());
        end
        step(1'b0);
        n_tests++;
        if (tick_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_regrant: gnt=%b, required 1", tick_gnt);
        end
        step(1'b0);
        n_tests++;
        if (tick_gnt !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_regrant: gnt=%b, required 0", tick_gnt);
        end
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 6) begin
            n_fail++;
            $display("FAIL bp_count: got %0d responses, required 6", got_q.size());
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i].data !== exp_q[i].data || got_q[i].err !== exp_q[i].err) begin
                n_fail++;
                $display("FAIL bp_rsp[%0d]: got %h/%b, required %h/%b",
                         i, got_q[i].data, got_q[i].err, exp_q[i].data, exp_q[i].err);
            end
        end
    endtask

    task automatic test_reset_midop();
        bit          ok;
        logic [31:0] val;
        val = $urandom;
        clear_logs();
        add(32'h30, 1'b1, val, 4'hF);
        drain(100, 1'b0, ok);
        clear_logs();
        for (int i = 0; i < 3; i++) add(32'h30, 1'b0, 32'h0, 4'h0);
        repeat (4) step(1'b0);
        n_tests++;
        if (rvalid_o !== 1'b1 || exp_q.size() != 3) begin
            n_fail++;
            $display("FAIL rst_setup: rvalid=%b granted=%0d, required 1 / 3", rvalid_o, exp_q.size());
        end
        rstn_i = 1'b0;
        #1;
        n_tests++;
        if (rvalid_o !== 1'b0 || rdata_o !== '0) begin
            n_fail++;
            $display("FAIL rst_discard: rvalid=%b rdata=%h, required 0 / 0", rvalid_o, rdata_o);
        end
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h30; wdata_i = 32'hFFFFFFFF; be_i = 4'hF;
        #1;
        n_tests++;
        if (ram_en_o !== 1'b0 || ram_we_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_no_write: en=%b we=%b, required 0 0", ram_en_o, ram_we_o);
        end
        req_i = 1'b0; we_i = 1'b0;
        tick();
        rstn_i = 1'b1;
        clear_logs();
        n_tests++;
        if (dut.cnt !== '0) begin
            n_fail++;
            $display("FAIL rst_cnt: cnt=%0d, required 0", dut.cnt);
        end
        add(32'h30, 1'b0, 32'h0, 4'h0);
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 1 || got_q[0].data !== val || got_q[0].err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_first_read: %0d rsps data %h err %b, required 1 / %h / 0",
                     got_q.size(), got_q[0].data, got_q[0].err, val);
        end
    endtask

    task automatic test_oor();
        bit          ok;
        logic [31:0] val;
        val = $urandom;
        clear_logs();
`ifdef SP_RAM_MASTER_OOR_ERR_EN
        add(32'h8000, 1'b1, val, 4'hF);
        add(32'h0, 1'b0, 32'h0, 4'h0);
        step(1'b1);
        n_tests++;
        if (tick_gnt !== 1'b1 || tick_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_ram_en: gnt=%b en=%b, required 1 / 0", tick_gnt, tick_en);
        end
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 2 || got_q[0].err !== 1'b1 || got_q[0].data !== '0 ||
            got_q[1].err !== 1'b0 || got_q[1].data !== exp_q[1].data) begin
            n_fail++;
            $display("FAIL oor_rsp: %0d rsps, first %h/%b second %h/%b, required 2 / 0/1 / %h/0",
                     got_q.size(), got_q[0].data, got_q[0].err, got_q[1].data, got_q[1].err, exp_q[1].data);
        end
`else
        add(32'h8044, 1'b1, val, 4'hF);
        add(32'h44, 1'b0, 32'h0, 4'h0);
        step(1'b1);
        n_tests++;
        if (tick_gnt !== 1'b1 || tick_en !== 1'b1) begin
            n_fail++;
            $display("FAIL alias_ram_en: gnt=%b en=%b, required 1 / 1", tick_gnt, tick_en);
        end
        drain(100, 1'b0, ok);
        n_tests++;
        if (!ok || got_q.size() != 2 || got_q[0].err !== 1'b0 || got_q[1].data !== val || got_q[1].err !== 1'b0) begin
            n_fail++;
            $display("FAIL alias_rsp: %0d rsps, read %h err %b, required 2 / %h / 0",
                     got_q.size(), got_q[1].data, got_q[1].err, val);
        end
`endif
    endtask

    task automatic test_random();
        bit          ok;
        logic [31:0] a;
        clear_logs();
        for (int i = 0; i < 60; i++) begin
            a = 32'(4 * $urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) a = a | 32'h8000;
            add(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
        end
        drain(1000, 1'b1, ok);
        n_tests++;
        if (!ok || got_q.size() != 60 || exp_q.size() != 60) begin
            n_fail++;
            $display("FAIL rand_count: %0d rsps for %0d grants, required 60", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got_q.size() || got_q[i].data !== exp_q[i].data || got_q[i].err !== exp_q[i].err) begin
                n_fail++;
                $display("FAIL rand_rsp[%0d]: got %h/%b, required %h/%b",
                         i, got_q[i].data, got_q[i].err, exp_q[i].data, exp_q[i].err);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_byte_write();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
        test_oor();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
